sifh_peak_finder: RTL and testbench
===================================

SIFH_PEAK_FINDER -- requirements
Module: sifh_peak_finder

Interface
REQ-001 Parameter NP, default 10: histogram bin index width; one pixel has 2^NP bins.
REQ-002 Parameter PEAK_MAX, default 8: bin count width.
REQ-003 Parameter PIXELS, default 2: pixels per histogram RAM; PIX_W = clog2(PIXELS), address width NB = PIX_W + NP.
REQ-004 Parameter CLR_EN, default 1: when 1, each bin is zeroed after it is read.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 res  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse from the histogram FSM: all PIXELS histograms complete.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 raddr  out  NB  RAM read address = {pixel, bin}.
REQ-010 rEnable  out  1  RAM read strobe, active-low.
REQ-011 readFlag  out  1  RAM port-b memory enable, active-high.
REQ-012 rdata  in  PEAK_MAX  RAM read data, valid exactly 1 cycle after the strobe.
REQ-013 waddr  out  NB  clear-write address.
REQ-014 wEnable  out  1  clear-write strobe, active-high.
REQ-015 writeFlag  out  1  RAM port-a memory enable, active-high.
REQ-016 wdata  out  PEAK_MAX  clear data, constant 0.
REQ-017 peak_pix  out  PIX_W  pixel index of the presented result.
REQ-018 peak_bin  out  NP  bin index of the maximum count.
REQ-019 peak_cnt  out  PEAK_MAX  maximum count; 0 means no events.
REQ-020 peak_valid  out  1  result valid; held with stable data until peak_ready.
REQ-021 peak_ready  in  1  downstream accepts when peak_valid & peak_ready.
REQ-022 done  out  1  one-cycle pulse after the last pixel's result is accepted.

Function
REQ-023 FSM states: IDLE, SCAN, DRAIN, PRESENT, DONE.
REQ-024 IDLE: start=1 -> SCAN, pixel=0, bin=0, best_cnt=0, best_bin=0; start in any other state is ignored.
REQ-025 SCAN: raddr={pixel,bin}, rEnable=0, readFlag=1 each cycle; bin increments; after bin 2^NP-1 is issued -> DRAIN.
REQ-026 One-cycle read pipeline: rdata in cycle t pairs with the address issued in t-1; a delayed address register tracks it.
REQ-027 Compare: replace best only if rdata > best_cnt (strict); ties keep the lowest bin.
REQ-028 CLR_EN=1: in the rdata cycle, wEnable=1, writeFlag=1, waddr=delayed address, wdata=0; read and clear target different bins in the same cycle.
REQ-029 DRAIN: one cycle consumes the last rdata, then -> PRESENT; the scan of one pixel takes 2^NP+1 cycles.
REQ-030 PRESENT: peak_valid=1 with registered peak_pix/bin/cnt; on handshake, if pixel<PIXELS-1 -> SCAN with pixel+1 and best cleared, else -> DONE.
REQ-031 peak_ready may be held high; the handshake then completes in the first PRESENT cycle.
REQ-032 DONE: done=1 for one cycle -> IDLE; busy=0 in IDLE.
REQ-033 All-zero histogram: peak_bin=0, peak_cnt=0.
REQ-034 Saturated count (all ones) is a legal maximum; no overflow handling.
REQ-035 Outside SCAN and DRAIN: rEnable=1, readFlag=0, wEnable=0, writeFlag=0.

Reset
REQ-036 res=0 asynchronously forces IDLE, all counters and best registers to 0, peak_valid=0, done=0, busy=0, rEnable=1, readFlag/wEnable/writeFlag=0, raddr=waddr=0.
REQ-037 Reset mid-scan abandons the pixel; no result is presented and partially cleared bins stay as written.

Structure
REQ-038 NP, PEAK_MAX, PIXELS defaults and the state encoding live in the shared SiFH parameters package/header.
REQ-039 One sub-module sifh_max_cmp: registered strict-greater compare/update of best_cnt and best_bin, with clear.

Verification (NP=4, PEAK_MAX=8, PIXELS=2, 1-cycle RAM model)
REQ-040 Pixel 0 bin 5=9, others 0; pixel 1 bin 12=200 -> results (0,5,9) then (1,12,200), then done pulse.
REQ-041 Pixel 0 bins 3 and 7 both =50 -> peak_bin=3, peak_cnt=50 (tie keeps lowest).
REQ-042 CLR_EN=1, full scan -> all 32 RAM words read back 0; CLR_EN=0 -> contents unchanged, wEnable never 1.
REQ-043 peak_ready low for 10 cycles in PRESENT -> peak_valid and data stable; no reads issued; accepted on the first cycle ready=1.
REQ-044 Second start pulse mid-SCAN -> ignored; exactly 2 results and 1 done.
REQ-045 res=0 at bin 8 of pixel 0 -> outputs at reset values immediately; a new start rescans from pixel 0, bin 0.

Source files
------------

// File: rtl/sifh_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// sifh_peak_finder_pkg
// Shared SiFH parameters for the histogram peak finder: default geometry
// (bins per pixel, count width, pixels per RAM), the peak-finder FSM state
// encoding and a width helper for the pixel index.
// -----------------------------------------------------------------------------
package sifh_peak_finder_pkg;

  localparam int NP_DEF       = 10;  // bin index width, 2^NP bins per pixel
  localparam int PEAK_MAX_DEF = 8;   // bin count width
  localparam int PIXELS_DEF   = 2;   // pixels sharing one histogram RAM

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Pixel index width. A single-pixel RAM still gets a 1-bit index so that
  // no port or register collapses to zero width.
  function automatic int pixWidth(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/sifh_peak_finder_if.sv
// -----------------------------------------------------------------------------
// sifh_peak_finder_if
// Bus bundle between the peak finder, its histogram RAM and the result sink.
//   RAM read  : raddr, rEnable (active-low strobe), readFlag (port-b enable),
//               rdata (valid one cycle after the strobe)
//   RAM clear : waddr, wEnable, writeFlag (port-a enable), wdata (always 0)
//   Result    : peak_pix, peak_bin, peak_cnt, peak_valid / peak_ready
// master = peak finder side, slave = RAM + result consumer side.
// -----------------------------------------------------------------------------
interface sifh_peak_finder_if
  import sifh_peak_finder_pkg::*;
#(
  parameter int NP       = NP_DEF,
  parameter int PEAK_MAX = PEAK_MAX_DEF,
  parameter int PIXELS   = PIXELS_DEF
);

  localparam int PIX_W = pixWidth(PIXELS);
  localparam int NB    = PIX_W + NP;

  logic [NB-1:0]       raddr;
  logic                rEnable;
  logic                readFlag;
  logic [PEAK_MAX-1:0] rdata;

  logic [NB-1:0]       waddr;
  logic                wEnable;
  logic                writeFlag;
  logic [PEAK_MAX-1:0] wdata;

  logic [PIX_W-1:0]    peak_pix;
  logic [NP-1:0]       peak_bin;
  logic [PEAK_MAX-1:0] peak_cnt;
  logic                peak_valid;
  logic                peak_ready;

  modport master (
    output raddr, rEnable, readFlag,
    input  rdata,
    output waddr, wEnable, writeFlag, wdata,
    output peak_pix, peak_bin, peak_cnt, peak_valid,
    input  peak_ready
  );

  modport slave (
    input  raddr, rEnable, readFlag,
    output rdata,
    input  waddr, wEnable, writeFlag, wdata,
    input  peak_pix, peak_bin, peak_cnt, peak_valid,
    output peak_ready
  );

endinterface

// File: rtl/sifh_max_cmp.sv
// -----------------------------------------------------------------------------
// sifh_max_cmp
// Running maximum over a stream of (bin, count) pairs. A new pair replaces the
// held best only when its count is strictly greater, so on a tie the earlier
// (lower) bin is kept. clr zeroes the best registers for the next pixel.
//   clk, res     : clock, asynchronous active-low reset
//   clr          : synchronous clear of bestCnt/bestBin
//   valid        : cnt/bin carry a RAM read result this cycle
//   cnt, bin     : count read from RAM and the bin it belongs to
//   bestCnt/Bin  : registered running maximum and its bin
// -----------------------------------------------------------------------------
module sifh_max_cmp #(
  parameter int NP       = 10,
  parameter int PEAK_MAX = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic                clr,
  input  logic                valid,
  input  logic [PEAK_MAX-1:0] cnt,
  input  logic [NP-1:0]       bin,
  output logic [PEAK_MAX-1:0] bestCnt,
  output logic [NP-1:0]       bestBin
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      bestCnt <= '0;
      bestBin <= '0;
    end else if (clr) begin
      bestCnt <= '0;
      bestBin <= '0;
    end else if (valid && (cnt > bestCnt)) begin
      bestCnt <= cnt;
      bestBin <= bin;
    end
  end

endmodule

// File: rtl/sifh_peak_finder.sv
// -----------------------------------------------------------------------------
// sifh_peak_finder
// After the histogram FSM signals that all PIXELS histograms are complete,
// scans every bin of every pixel, finds the bin with the largest count
// (lowest bin wins ties), optionally zeroes each bin behind the read, and
// presents one (pixel, bin, count) result per pixel on a valid/ready port.
//   clk    : clock, rising edge
//   res    : asynchronous active-low reset
//   start  : one-cycle pulse, accepted only in IDLE
//   busy   : high from the cycle after an accepted start until back in IDLE
//   done   : one-cycle pulse after the last pixel's result is accepted
//   bus    : RAM read/clear ports and the result handshake (master side)
// -----------------------------------------------------------------------------
module sifh_peak_finder
  import sifh_peak_finder_pkg::*;
#(
  parameter int NP       = NP_DEF,
  parameter int PEAK_MAX = PEAK_MAX_DEF,
  parameter int PIXELS   = PIXELS_DEF,
  parameter bit CLR_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               start,
  output logic               busy,
  output logic               done,
  sifh_peak_finder_if.master bus
);

  localparam int PIX_W = pixWidth(PIXELS);
  localparam int NB    = PIX_W + NP;

  localparam logic [NP-1:0]    BIN_LAST = '1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  state_t              state;
  logic [PIX_W-1:0]    pixel;
  logic [NP-1:0]       bin;
  logic [NB-1:0]       raddrQ;
  logic                rEnableQ;
  logic                readFlagQ;
  logic [NB-1:0]       dAddr;     // address whose data is on rdata this cycle
  logic                rdValid;   // rdata carries a result this cycle
  logic                peakValidQ;

  logic [PIX_W-1:0]    pixelNext;
  logic [NP-1:0]       binNext;
  logic                bestClr;
  logic [PEAK_MAX-1:0] bestCnt;
  logic [NP-1:0]       bestBin;

  assign pixelNext = pixel + PIX_W'(1);
  assign binNext   = bin + NP'(1);

  // Best is cleared at the start of every pixel's scan: on an accepted start
  // and on each result handshake.
  assign bestClr = ((state == IDLE) && start) ||
                   ((state == PRESENT) && bus.peak_ready);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      pixel      <= '0;
      bin        <= '0;
      raddrQ     <= '0;
      rEnableQ   <= 1'b1;
      readFlagQ  <= 1'b0;
      dAddr      <= '0;
      rdValid    <= 1'b0;
      peakValidQ <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // One-cycle RAM latency: whatever is strobed now returns next cycle,
      // so the address and a valid flag follow the strobe by one register.
      rdValid <= ~rEnableQ;
      if (!rEnableQ) dAddr <= raddrQ;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            pixel     <= '0;
            bin       <= '0;
            raddrQ    <= '0;
            rEnableQ  <= 1'b0;
            readFlagQ <= 1'b1;
            busy      <= 1'b1;
          end
        end

        SCAN: begin
          if (bin == BIN_LAST) begin
            state     <= DRAIN;
            rEnableQ  <= 1'b1;
            readFlagQ <= 1'b0;
          end else begin
            bin    <= binNext;
            raddrQ <= {pixel, binNext};
          end
        end

        // Last read's data is compared during this cycle.
        DRAIN: begin
          state      <= PRESENT;
          peakValidQ <= 1'b1;
        end

        PRESENT: begin
          if (bus.peak_ready) begin
            peakValidQ <= 1'b0;
            if (pixel != PIX_LAST) begin
              state     <= SCAN;
              pixel     <= pixelNext;
              bin       <= '0;
              raddrQ    <= {pixelNext, {NP{1'b0}}};
              rEnableQ  <= 1'b0;
              readFlagQ <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  sifh_max_cmp #(
    .NP       (NP),
    .PEAK_MAX (PEAK_MAX)
  ) u_max_cmp (
    .clk     (clk),
    .res     (res),
    .clr     (bestClr),
    .valid   (rdValid),
    .cnt     (bus.rdata),
    .bin     (dAddr[NP-1:0]),
    .bestCnt (bestCnt),
    .bestBin (bestBin)
  );

  assign bus.raddr    = raddrQ;
  assign bus.rEnable  = rEnableQ;
  assign bus.readFlag = readFlagQ;

  // The clear write trails the read by one cycle, so it always targets the
  // bin read in the previous cycle while the current read hits the next bin.
  assign bus.waddr     = dAddr;
  assign bus.wEnable   = CLR_EN & rdValid;
  assign bus.writeFlag = CLR_EN & rdValid;
  assign bus.wdata     = '0;

  // The best registers only change on a handshake or during a scan, so they
  // are stable for as long as peak_valid is held.
  assign bus.peak_pix   = pixel;
  assign bus.peak_bin   = bestBin;
  assign bus.peak_cnt   = bestCnt;
  assign bus.peak_valid = peakValidQ;

endmodule

// File: tb/tb_sifh_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_sifh_peak_finder
// Two peak finders in lockstep (CLR_EN=1 and CLR_EN=0), each with its own
// 1-cycle histogram RAM. Expected peaks come from a reference model: the
// maximum of each pixel's bins and the lowest bin holding that maximum.
// -----------------------------------------------------------------------------
module tb_sifh_peak_finder;

  localparam int NP       = 4;
  localparam int PEAK_MAX = 8;
  localparam int PIXELS   = 2;
  localparam int NBINS    = 1 << NP;
  localparam int WORDS    = NBINS * PIXELS;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic busy0, done0, busy1, done1;

  int nChecks = 0;
  int nFails  = 0;

  sifh_peak_finder_if #(.NP(NP), .PEAK_MAX(PEAK_MAX), .PIXELS(PIXELS)) if0 ();
  sifh_peak_finder_if #(.NP(NP), .PEAK_MAX(PEAK_MAX), .PIXELS(PIXELS)) if1 ();

  sifh_peak_finder #(.NP(NP), .PEAK_MAX(PEAK_MAX), .PIXELS(PIXELS), .CLR_EN(1'b1)) dut (
    .clk(clk), .res(res), .start(start), .busy(busy0), .done(done0), .bus(if0)
  );

  sifh_peak_finder #(.NP(NP), .PEAK_MAX(PEAK_MAX), .PIXELS(PIXELS), .CLR_EN(1'b0)) dut_nc (
    .clk(clk), .res(res), .start(start), .busy(busy1), .done(done1), .bus(if1)
  );

  assign if0.peak_ready = ready;
  assign if1.peak_ready = ready;

  always #5 clk = ~clk;

  // Histogram RAMs with a bench-side load port.
  logic [7:0] mem0 [WORDS];
  logic [7:0] mem1 [WORDS];
  logic       ldEn = 1'b0;
  logic [4:0] ldAddr = '0;
  logic [7:0] ldData = '0;

  always @(posedge clk) begin
    if (ldEn) begin
      mem0[ldAddr] <= ldData;
      mem1[ldAddr] <= ldData;
    end
    if (!if0.rEnable && if0.readFlag) if0.rdata <= mem0[if0.raddr];
    if (!if1.rEnable && if1.readFlag) if1.rdata <= mem1[if1.raddr];
    if (if0.wEnable && if0.writeFlag) mem0[if0.waddr] <= if0.wdata;
    if (if1.wEnable && if1.writeFlag) mem1[if1.waddr] <= if1.wdata;
  end

  // Per-frame event counters.
  logic clrMon = 1'b0;
  int readCnt, doneCnt, acceptCnt, wen1Cnt, flagErr, stepErr;

  always @(posedge clk) begin
    if (clrMon) begin
      readCnt <= 0; doneCnt <= 0; acceptCnt <= 0;
      wen1Cnt <= 0; flagErr <= 0; stepErr <= 0;
    end else if (res) begin
      if (!if0.rEnable) readCnt <= readCnt + 1;
      if (done0) doneCnt <= doneCnt + 1;
      if (if0.peak_valid && ready) acceptCnt <= acceptCnt + 1;
      if (if1.wEnable || if1.writeFlag) wen1Cnt <= wen1Cnt + 1;
      if ((if0.readFlag == if0.rEnable) || (if0.wEnable != if0.writeFlag) ||
          (if0.wdata != 8'd0))
        flagErr <= flagErr + 1;
      if ({busy0, done0, if0.peak_valid, if0.rEnable, if0.raddr} !=
          {busy1, done1, if1.peak_valid, if1.rEnable, if1.raddr})
        stepErr <= stepErr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int img   [WORDS];
  int snap0 [WORDS];
  int snap1 [WORDS];

  task automatic load_img();
    for (int a = 0; a < WORDS; a++) begin
      @(negedge clk);
      ldEn   = 1'b1;
      ldAddr = a[4:0];
      ldData = img[a][7:0];
    end
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  task automatic fill_random(input int maxv);
    for (int a = 0; a < WORDS; a++) img[a] = $urandom_range(maxv, 0);
  endtask

  // Reference: peak count is the pixel's maximum; peak bin is the lowest bin
  // holding that maximum (bin 0 for an all-zero pixel).
  task automatic expect_peak(input int which, input int p, output int bb, output int bc);
    int mx, v;
    mx = 0;
    for (int b = 0; b < NBINS; b++) begin
      v = which ? snap1[p*NBINS+b] : snap0[p*NBINS+b];
      if (v > mx) mx = v;
    end
    bb = 0;
    for (int b = NBINS - 1; b >= 0; b--) begin
      v = which ? snap1[p*NBINS+b] : snap0[p*NBINS+b];
      if (v == mx) bb = b;
    end
    bc = mx;
  endtask

  task automatic run_frame(input int stall, input bit holdReady, input bit midStart);
    int n, eb0, ec0, eb1, ec1, nz, diff;
    for (int a = 0; a < WORDS; a++) begin
      snap0[a] = int'(mem0[a]);
      snap1[a] = int'(mem1[a]);
    end
    @(negedge clk); clrMon = 1'b1;
    @(negedge clk); clrMon = 1'b0; start = 1'b1; ready = holdReady;
    @(negedge clk); start = 1'b0;
    check("busy after start", busy0, 1);
    check("first raddr", if0.raddr, 0);
    check("first rEnable", if0.rEnable, 0);
    for (int p = 0; p < PIXELS; p++) begin
      n = 1;
      while (!if0.peak_valid && n < 200) begin
        start = midStart && (p == 0) && (n == 4);
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      if (!if0.peak_valid) begin
        check("peak_valid timeout", 0, 1);
        ready = 1'b0;
        return;
      end
      if (p == 0) check("scan latency", n, NBINS + 2);
      expect_peak(0, p, eb0, ec0);
      expect_peak(1, p, eb1, ec1);
      check("peak_pix", if0.peak_pix, p);
      check("peak_bin", if0.peak_bin, eb0);
      check("peak_cnt", if0.peak_cnt, ec0);
      check("nc peak_valid", if1.peak_valid, 1);
      check("nc peak_bin", if1.peak_bin, eb1);
      check("nc peak_cnt", if1.peak_cnt, ec1);
      if (!holdReady) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall valid", if0.peak_valid, 1);
          check("stall pix", if0.peak_pix, p);
          check("stall bin", if0.peak_bin, eb0);
          check("stall cnt", if0.peak_cnt, ec0);
          check("stall no read", if0.rEnable, 1);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end else begin
        @(negedge clk);
      end
      check("valid drop", if0.peak_valid, 0);
    end
    check("done pulse", done0, 1);
    repeat (3) @(negedge clk);
    ready = 1'b0;
    check("busy idle", busy0, 0);
    check("done count", doneCnt, 1);
    check("accept count", acceptCnt, PIXELS);
    check("read count", readCnt, WORDS);
    check("flag errors", flagErr, 0);
    check("lockstep errors", stepErr, 0);
    check("nc write strobes", wen1Cnt, 0);
    nz = 0;
    diff = 0;
    for (int a = 0; a < WORDS; a++) begin
      if (mem0[a] != 8'd0) nz++;
      if (int'(mem1[a]) != snap1[a]) diff++;
    end
    check("cleared words nonzero", nz, 0);
    check("nc words changed", diff, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 res = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst rEnable", if0.rEnable, 1);
    check("rst readFlag", if0.readFlag, 0);
    check("rst wEnable", if0.wEnable, 0);
    check("rst raddr", if0.raddr, 0);
    check("rst peak_valid", if0.peak_valid, 0);
    res = 1'b1;
    repeat (2) @(negedge clk);

    // Single peaks: pixel 0 bin 5 = 9, pixel 1 bin 12 = 200.
    for (int a = 0; a < WORDS; a++) img[a] = 0;
    img[5] = 9;
    img[NBINS + 12] = 200;
    load_img();
    run_frame(2, 1'b0, 1'b0);

    // Tie on pixel 0: bins 3 and 7 both hold the maximum 50.
    fill_random(49);
    img[3] = 50;
    img[7] = 50;
    for (int b = 0; b < NBINS; b++) img[NBINS + b] = $urandom_range(255, 0);
    load_img();
    run_frame(0, 1'b1, 1'b0);

    // Long back-pressure.
    fill_random(255);
    load_img();
    run_frame(10, 1'b0, 1'b0);

    // Extra start mid-scan must be ignored.
    fill_random(255);
    load_img();
    run_frame(1, 1'b0, 1'b1);

    // All-zero pixel 0; saturated tie on pixel 1.
    for (int a = 0; a < WORDS; a++) img[a] = (a < NBINS) ? 0 : $urandom_range(254, 0);
    img[NBINS + 9]  = 255;
    img[NBINS + 14] = 255;
    load_img();
    run_frame(0, 1'b0, 1'b0);

    // Random frames, small ranges give frequent ties.
    for (int k = 0; k < 4; k++) begin
      fill_random((k < 2) ? 3 : 255);
      load_img();
      run_frame(k, k[0], 1'b0);
    end

    // Reset in the middle of pixel 0's scan, then a clean rescan.
    fill_random(255);
    load_img();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (if0.raddr != 5'd8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached bin 8", if0.raddr, 8);
    res = 1'b0;
    #1;
    check("mid rst busy", busy0, 0);
    check("mid rst rEnable", if0.rEnable, 1);
    check("mid rst readFlag", if0.readFlag, 0);
    check("mid rst wEnable", if0.wEnable, 0);
    check("mid rst writeFlag", if0.writeFlag, 0);
    check("mid rst raddr", if0.raddr, 0);
    check("mid rst waddr", if0.waddr, 0);
    check("mid rst peak_valid", if0.peak_valid, 0);
    check("mid rst nc rEnable", if1.rEnable, 1);
    repeat (2) @(negedge clk);
    res = 1'b1;
    repeat (4) @(negedge clk);
    check("post rst peak_valid", if0.peak_valid, 0);
    check("post rst busy", busy0, 0);
    check("post rst rEnable", if0.rEnable, 1);
    run_frame(3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
